// File: rtl/pic_pkg.sv
// Shared types, constants and helpers for the 8259A interrupt acknowledge path.
package pic_pkg;

    // Acknowledge sequence states. W* waits for the next INTA falling edge,
    // P* means an INTA pulse is currently low.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_P1,
        ST_W2,
        ST_P2,
        ST_W3,
        ST_P3
    } state_t;

    // 8080/85 CALL instruction opcode returned on the first INTA pulse.
    localparam logic [7:0] CALL_OPCODE    = 8'hCD;

    // Level reported when the request vanished before the first INTA.
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Binary index of a one-hot vector (0 when the vector is empty).
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Isolate the lowest set bit (highest priority in fixed-priority order).
    function automatic logic [7:0] lowest_set_onehot(input logic [7:0] vec);
        return vec & 8'(~vec + 8'd1);
    endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Synchronizes the asynchronous inta_n pin and produces one-cycle
// fall/rise strobes from the last synchronizer stage.
module inta_edge_detect #(
    parameter int INTA_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic [INTA_SYNC-1:0] sync;
    logic                 prev;

    // Synchronizer chain plus one delayed copy of the last stage; all flops
    // reset to 1 so reset release never looks like an acknowledge edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[INTA_SYNC-2:0], inta_n};
            prev <= sync[INTA_SYNC-1];
        end
    end

    assign fall = prev & ~sync[INTA_SYNC-1];
    assign rise = ~prev & sync[INTA_SYNC-1];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// CPU side of the 8259A request path: raises INT, runs the 8086 or
// 8080/85 INTA pulse sequence, drives vector/CALL bytes and owns the ISR.
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter int INTA_SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] interrupt,
    input  logic       mode_8086,
    input  logic       aeoi,
    input  logic [4:0] vector_base,
    input  logic [2:0] call_addr_lo,
    input  logic [7:0] call_addr_hi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       inta_n,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       ack_busy
);

    logic       fall;
    logic       rise;

    state_t     state_q, state_d;
    logic       int_q, int_d;
    logic       oe_q, oe_d;
    logic       spur_q, spur_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] level_q, level_d;

    logic [7:0] set_mask;
    logic [7:0] aeoi_mask;
    logic [7:0] eoi_mask;
    logic       final_rise;

    inta_edge_detect #(
        .INTA_SYNC (INTA_SYNC)
    ) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    // Next-state, output-byte and ISR update logic for the INTA sequence.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        int_d      = int_q;
        oe_d       = oe_q;
        spur_d     = spur_q;
        dout_d     = dout_q;
        level_d    = level_q;
        set_mask   = 8'h00;
        aeoi_mask  = 8'h00;
        eoi_mask   = 8'h00;
        final_rise = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (interrupt != 8'h00) begin
                    state_d = ST_REQ;
                    int_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (fall) begin
                    state_d = ST_P1;
                    int_d   = 1'b0;
                    if (interrupt == 8'h00) begin
                        level_d = SPURIOUS_LEVEL;
                        spur_d  = 1'b1;
                    end else begin
                        level_d  = onehot_to_index(interrupt);
                        spur_d   = 1'b0;
                        set_mask = 8'b1 << onehot_to_index(interrupt);
                    end
                    if (mode_8086) begin
                        oe_d = 1'b0;
                    end else begin
                        dout_d = CALL_OPCODE;
                        oe_d   = 1'b1;
                    end
                end
            end
            ST_P1: begin
                if (rise) begin
                    state_d = ST_W2;
                    oe_d    = 1'b0;
                end
            end
            ST_W2: begin
                if (fall) begin
                    state_d = ST_P2;
                    dout_d  = mode_8086 ? {vector_base, level_q}
                                        : {call_addr_lo, level_q, 2'b00};
                    oe_d    = 1'b1;
                end
            end
            ST_P2: begin
                if (rise) begin
                    oe_d = 1'b0;
                    if (mode_8086) begin
                        state_d    = ST_IDLE;
                        final_rise = 1'b1;
                    end else begin
                        state_d = ST_W3;
                    end
                end
            end
            ST_W3: begin
                if (fall) begin
                    state_d = ST_P3;
                    dout_d  = call_addr_hi;
                    oe_d    = 1'b1;
                end
            end
            ST_P3: begin
                if (rise) begin
                    state_d    = ST_IDLE;
                    oe_d       = 1'b0;
                    final_rise = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (final_rise && aeoi && !spur_q) begin
            aeoi_mask = 8'b1 << level_q;
        end

        if (eoi_valid) begin
            eoi_mask = eoi_specific ? (8'b1 << eoi_level) : lowest_set_onehot(isr_q);
        end

        // Clears are applied before the set, so a set on the same bit wins.
        isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
    end

    // State and registered outputs; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            oe_q    <= 1'b0;
            spur_q  <= 1'b0;
            dout_q  <= 8'h00;
            isr_q   <= 8'h00;
            level_q <= 3'd0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            oe_q    <= oe_d;
            spur_q  <= spur_d;
            dout_q  <= dout_d;
            isr_q   <= isr_d;
            level_q <= level_d;
        end
    end

    assign int_out             = int_q;
    assign data_oe             = oe_q;
    assign data_out            = dout_q;
    assign in_service_register = isr_q;
    assign ack_busy            = (state_q != ST_IDLE);

endmodule
